// File: rtl/slap_rom_loader_pkg.sv
// Slap Fight / Tiger Heli ROM download map, FSM states and map helpers.
// Region bases and sizes are byte addresses in the ioctl image.
package slap_rom_loader_pkg;

  localparam int AW = 25;
  typedef logic [AW-1:0] addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam addr_t EP_BASE_1 = 25'h000_0000;
  localparam addr_t EP_BASE_2 = 25'h000_8000;
  localparam addr_t EP_BASE_3 = 25'h000_C000;
  localparam addr_t EP_BASE_4 = 25'h000_E000;
  localparam addr_t EP_BASE_5 = 25'h001_0000;

  localparam addr_t EP_SIZE_1 = 25'h000_8000;
  localparam addr_t EP_SIZE_2 = 25'h000_4000;
  localparam addr_t EP_SIZE_3 = 25'h000_2000;
  localparam addr_t EP_SIZE_4 = 25'h000_2000;

  localparam addr_t BG_SIZE32 = 25'h000_8000;
  localparam addr_t BG_SIZE16 = 25'h000_4000;

  localparam addr_t TOTAL_32 = 25'h003_0000;
  localparam addr_t TOTAL_16 = 25'h002_0000;

  function automatic addr_t bg_size(input logic pcb);
    return pcb ? BG_SIZE16 : BG_SIZE32;
  endfunction

  function automatic addr_t ep_size(
    input int unsigned i,
    input logic        pcb
  );
    case (i)
      0:       return EP_SIZE_1;
      1:       return EP_SIZE_2;
      2:       return EP_SIZE_3;
      3:       return EP_SIZE_4;
      default: return bg_size(pcb);
    endcase
  endfunction

  // ep5..ep8 sit back to back, so their bases move with the BG size
  function automatic addr_t ep_base(
    input int unsigned i,
    input logic        pcb
  );
    case (i)
      0:       return EP_BASE_1;
      1:       return EP_BASE_2;
      2:       return EP_BASE_3;
      3:       return EP_BASE_4;
      default: return EP_BASE_5 + addr_t'(i - 4) * bg_size(pcb);
    endcase
  endfunction

endpackage

// File: rtl/slap_rom_loader_if.sv
// ioctl download bus between the HPS side (master) and the loader (slave).
interface slap_rom_loader_if;

  logic        dn_download;
  logic [7:0]  dn_index;
  logic [24:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        dn_wait;

  modport master (
    output dn_download,
    output dn_index,
    output dn_addr,
    output dn_data,
    output dn_wr,
    input  dn_wait
  );

  modport slave (
    input  dn_download,
    input  dn_index,
    input  dn_addr,
    input  dn_data,
    input  dn_wr,
    output dn_wait
  );

endinterface

// File: rtl/slap_rom_region_dec.sv
// Address decoder: ioctl byte address -> one-hot EPROM select and
// region-relative offset. MAP_SHIFT scales the whole map down.
module slap_rom_region_dec
  import slap_rom_loader_pkg::*;
#(
  parameter int NUM_EP    = 8,
  parameter int MAP_SHIFT = 0
) (
  input  addr_t             addr,
  input  logic              pcb,
  output logic [NUM_EP-1:0] cs,
  output addr_t             off,
  output logic              miss
);

  addr_t base;
  addr_t size;
  logic  hit;

  always_comb begin
    cs   = '0;
    off  = '0;
    hit  = 1'b0;
    base = '0;
    size = '0;
    for (int unsigned i = 0; i < NUM_EP; i++) begin
      base = ep_base(i, pcb) >> MAP_SHIFT;
      size = ep_size(i, pcb) >> MAP_SHIFT;
      if (!hit && addr >= base &&
          (addr - base) < size) begin
        cs[i] = 1'b1;
        off   = addr - base;
        hit   = 1'b1;
      end
    end
    miss = !hit;
  end

endmodule

// File: rtl/slap_rom_loader.sv
// ROM download write path: ioctl byte stream -> registered EPROM
// write strobes, download sequencing, size check and CPU hold.
module slap_rom_loader
  import slap_rom_loader_pkg::*;
#(
  parameter int         NUM_EP    = 8,
  parameter int         WR_HOLD   = 2,
  parameter logic [7:0] ROM_INDEX = 8'd0,
  parameter int         MAP_SHIFT = 0
) (
  input  logic              master_clk,
  input  logic              reset_n,
  input  logic              pcb,
  slap_rom_loader_if.slave  dn,
  output logic [24:0]       ld_addr,
  output logic [7:0]        ld_data,
  output logic              ld_wr,
  output logic [NUM_EP-1:0] ep_cs,
  output logic              rom_ready,
  output logic              cpu_hold,
  output logic              load_err
);

  localparam int    WCW   = $clog2(WR_HOLD + 1);
  localparam addr_t TOT32 = TOTAL_32 >> MAP_SHIFT;
  localparam addr_t TOT16 = TOTAL_16 >> MAP_SHIFT;

  state_e            state_q;
  logic              dn_wr_q;
  logic [WCW-1:0]    wcnt_q;
  addr_t             byte_cnt_q;
  addr_t             ld_addr_q;
  logic [7:0]        ld_data_q;
  logic              ld_wr_q;
  logic [NUM_EP-1:0] ep_cs_q;
  logic              rom_ready_q;
  logic              cpu_hold_q;
  logic              load_err_q;

  logic [NUM_EP-1:0] dec_cs;
  addr_t             dec_off;
  logic              dec_miss;

  logic wr_edge, busy, in_load;
  logic accept, clash, start;
  addr_t total;

  slap_rom_region_dec #(
    .NUM_EP    (NUM_EP),
    .MAP_SHIFT (MAP_SHIFT)
  ) u_dec (
    .addr (dn.dn_addr),
    .pcb  (pcb),
    .cs   (dec_cs),
    .off  (dec_off),
    .miss (dec_miss)
  );

  assign wr_edge = dn.dn_wr & ~dn_wr_q;
  assign busy    = (wcnt_q != '0);
  assign in_load = (state_q == ST_LOAD);
  assign accept  = in_load & wr_edge & ~busy;
  assign clash   = in_load & wr_edge & busy;
  assign start   = dn.dn_download &
                   (dn.dn_index == ROM_INDEX) &
                   ((state_q == ST_IDLE) |
                    (state_q == ST_DONE));
  assign total   = pcb ? TOT16 : TOT32;

  // wait must cover the accepting cycle itself
  assign dn.dn_wait = accept | busy;

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      dn_wr_q     <= 1'b0;
      wcnt_q      <= '0;
      byte_cnt_q  <= '0;
      ld_addr_q   <= '0;
      ld_data_q   <= '0;
      ld_wr_q     <= 1'b0;
      ep_cs_q     <= '0;
      rom_ready_q <= 1'b0;
      cpu_hold_q  <= 1'b1;
      load_err_q  <= 1'b0;
    end else begin
      dn_wr_q <= dn.dn_wr;
      ld_wr_q <= accept;
      ep_cs_q <= accept ? dec_cs : '0;
      if (accept) begin
        ld_addr_q <= dec_off;
        ld_data_q <= dn.dn_data;
        wcnt_q    <= WCW'(WR_HOLD);
      end else if (busy) begin
        wcnt_q <= wcnt_q - 1'b1;
      end
      if (accept && byte_cnt_q != '1)
        byte_cnt_q <= byte_cnt_q + 1'b1;
      if ((accept && dec_miss) || clash)
        load_err_q <= 1'b1;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q     <= ST_LOAD;
            byte_cnt_q  <= '0;
            load_err_q  <= 1'b0;
            rom_ready_q <= 1'b0;
            cpu_hold_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (!dn.dn_download)
            state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (byte_cnt_q == total && !load_err_q) begin
            state_q     <= ST_DONE;
            rom_ready_q <= 1'b1;
            cpu_hold_q  <= 1'b0;
          end else begin
            state_q    <= ST_IDLE;
            load_err_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ld_addr   = ld_addr_q;
  assign ld_data   = ld_data_q;
  assign ld_wr     = ld_wr_q;
  assign ep_cs     = ep_cs_q;
  assign rom_ready = rom_ready_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_slap_rom_loader.sv
// Scoreboard bench for slap_rom_loader on a 1/32-scaled ROM map.
module tb_slap_rom_loader;

  localparam int SHIFT = 5;
  localparam int HOLD  = 2;
  localparam logic [24:0] EP5  = 25'h800;
  localparam logic [24:0] BG32 = 25'h400;
  localparam logic [24:0] BG16 = 25'h200;
  localparam logic [24:0] T32  = 25'h1800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pcb = 1'b0;
  logic [24:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_wr;
  logic [7:0]  ep_cs;
  logic        rom_ready;
  logic        cpu_hold;
  logic        load_err;

  slap_rom_loader_if dn ();

  slap_rom_loader #(
    .NUM_EP    (8),
    .WR_HOLD   (HOLD),
    .ROM_INDEX (8'd0),
    .MAP_SHIFT (SHIFT)
  ) dut (
    .master_clk (clk),
    .reset_n    (rst_n),
    .pcb        (pcb),
    .dn         (dn),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_wr      (ld_wr),
    .ep_cs      (ep_cs),
    .rom_ready  (rom_ready),
    .cpu_hold   (cpu_hold),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cs;
    logic [24:0] off;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;
  int n_strb = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [24:0] a,
                                 input logic p,
                                 input logic [7:0] d);
    exp_t e;
    logic [24:0] bg;
    int k;
    bg = p ? BG16 : BG32;
    e.data = d;
    e.cs = 8'h00;
    e.off = '0;
    if (a < 25'h400) begin
      e.cs = 8'h01; e.off = a;
    end else if (a < 25'h600) begin
      e.cs = 8'h02; e.off = a - 25'h400;
    end else if (a < 25'h700) begin
      e.cs = 8'h04; e.off = a - 25'h600;
    end else if (a < EP5) begin
      e.cs = 8'h08; e.off = a - 25'h700;
    end else if (a < EP5 + (bg << 2)) begin
      k = int'((a - EP5) / bg);
      e.cs = 8'h10 << k;
      e.off = (a - EP5) % bg;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (ld_wr) begin
      n_strb++;
      if (sb.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_cs", ep_cs, e.cs);
        if (e.cs != 8'h00)
          chk("sb_addr", ld_addr, e.off);
        chk("sb_data", ld_data, e.data);
      end
    end else if (rst_n) begin
      chk("cs_idle", ep_cs, 0);
    end
  end

  task automatic wait_free();
    int t;
    t = 0;
    while (dn.dn_wait) begin
      @(posedge clk); #1;
      t++;
      if (t > 20) begin
        chk("wait_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic wr(input logic [24:0] a,
                    input logic [7:0] d,
                    input bit acc);
    dn.dn_addr = a;
    dn.dn_data = d;
    dn.dn_wr = 1'b1;
    if (acc) sb.push_back(model(a, pcb, d));
    @(posedge clk); #1;
    dn.dn_wr = 1'b0;
    wait_free();
    if (!acc) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    dn.dn_index = idx;
    dn.dn_download = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic end_dl();
    dn.dn_download = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wait"}, dn.dn_wait, 0);
    chk({tag, "_ldwr"}, ld_wr, 0);
    chk({tag, "_cs"}, ep_cs, 0);
    chk({tag, "_addr"}, ld_addr, 0);
    chk({tag, "_data"}, ld_data, 0);
    chk({tag, "_rdy"}, rom_ready, 0);
    chk({tag, "_hold"}, cpu_hold, 1);
    chk({tag, "_err"}, load_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int w;
    logic [7:0] d;
    dn.dn_download = 1'b0;
    dn.dn_index = 8'd0;
    dn.dn_addr = '0;
    dn.dn_data = '0;
    dn.dn_wr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // foreign image index in IDLE
    s = n_strb;
    start_dl(8'd1);
    wr(25'h10, 8'h55, 0);
    end_dl();
    chk("idx_idle_strb", n_strb - s, 0);
    chk("idx_idle_hold", cpu_hold, 1);
    chk("idx_idle_rdy", rom_ready, 0);
    chk("idx_idle_err", load_err, 0);

    // Tiger Heli map, short image
    pcb = 1'b1;
    start_dl(8'd0);
    wr(EP5 + BG16, 8'h6E, 1);
    wr(25'h0, 8'h11, 1);
    wr(25'h401, 8'h22, 1);
    chk("short_err_mid", load_err, 0);
    end_dl();
    chk("short_err", load_err, 1);
    chk("short_hold", cpu_hold, 1);
    chk("short_rdy", rom_ready, 0);

    // held dn_wr, then an edge while busy
    start_dl(8'd0);
    chk("restart_err", load_err, 0);
    s = n_strb;
    w = 0;
    dn.dn_addr = 25'h123;
    dn.dn_data = 8'h9A;
    dn.dn_wr = 1'b1;
    sb.push_back(model(25'h123, pcb, 8'h9A));
    repeat (6) begin
      @(negedge clk);
      if (dn.dn_wait) w++;
    end
    @(posedge clk); #1;
    dn.dn_wr = 1'b0;
    wait_free();
    @(posedge clk); #1;
    chk("held_wait", w, 1 + HOLD);
    chk("held_strb", n_strb - s, 1);
    chk("held_err", load_err, 0);
    s = n_strb;
    dn.dn_addr = 25'h124;
    dn.dn_data = 8'h77;
    dn.dn_wr = 1'b1;
    sb.push_back(model(25'h124, pcb, 8'h77));
    @(posedge clk); #1;
    dn.dn_wr = 1'b0;
    @(posedge clk); #1;
    dn.dn_wr = 1'b1;
    @(posedge clk); #1;
    dn.dn_wr = 1'b0;
    wait_free();
    @(posedge clk); #1;
    chk("clash_err", load_err, 1);
    chk("clash_strb", n_strb - s, 1);
    end_dl();

    // byte outside every region
    start_dl(8'd0);
    chk("miss_pre_err", load_err, 0);
    wr(25'h1FF_FFFF, 8'hE1, 1);
    chk("miss_err", load_err, 1);
    end_dl();
    chk("miss_hold", cpu_hold, 1);

    // reset in mid-LOAD with an edge arriving
    start_dl(8'd0);
    wr(25'h20, 8'h3C, 1);
    dn.dn_addr = 25'h21;
    dn.dn_data = 8'hC3;
    dn.dn_wr = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    dn.dn_wr = 1'b0;
    dn.dn_download = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // full Slap Fight image, recovers from the failures above
    pcb = 1'b0;
    start_dl(8'd0);
    s = n_strb;
    for (int a = 0; a < int'(T32); a++) begin
      d = 8'(a ^ (a >> 8));
      if (25'(a) == EP5) d = 8'hA5;
      wr(25'(a), d, 1);
    end
    end_dl();
    chk("full_strb", n_strb - s, T32);
    chk("full_rdy", rom_ready, 1);
    chk("full_hold", cpu_hold, 0);
    chk("full_err", load_err, 0);

    // foreign image index while DONE
    s = n_strb;
    start_dl(8'd1);
    wr(25'h5, 8'h5A, 0);
    end_dl();
    chk("idx_done_strb", n_strb - s, 0);
    chk("idx_done_hold", cpu_hold, 0);
    chk("idx_done_rdy", rom_ready, 1);

    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
